// File: rtl/usb_fs_rx_pkg.sv
// Shared types and constants for the full-speed USB receive front end.
package usb_fs_rx_pkg;

  typedef enum logic [1:0] {
    J   = 2'd0,
    K   = 2'd1,
    SE0 = 2'd2,
    SE1 = 2'd3
  } line_state_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    EOP   = 3'd3,
    ABORT = 3'd4
  } rx_state_t;

  localparam int STUFF_RUN = 6;

  // Full-speed J: D+ high, D- low.
  localparam logic J_P = 1'b1;
  localparam logic J_N = 1'b0;

  function automatic line_state_t decode_line(input logic p, input logic n);
    line_state_t ls;
    if (p == J_P && n == J_N)      ls = J;
    else if (p != J_P && n != J_N) ls = K;
    else if (!p && !n)             ls = SE0;
    else                           ls = SE1;
    return ls;
  endfunction

endpackage

// File: rtl/usb_fs_rx_frontend_if.sv
// Framed serial bit stream from the USB receive front end to the packet decoder.
interface usb_fs_rx_frontend_if;
  import usb_fs_rx_pkg::*;

  // Valid-only stream, no ready: rx_bit is meaningful only while rx_bit_valid
  // is high and must be taken that cycle; rx_err is meaningful only with rx_pkt_end.
  logic      rx_active;
  logic      rx_pkt_start;
  logic      rx_bit_valid;
  logic      rx_bit;
  logic      rx_pkt_end;
  logic      rx_err;
  rx_state_t dbg_state;

  modport master (
    output rx_active, rx_pkt_start, rx_bit_valid, rx_bit, rx_pkt_end, rx_err, dbg_state
  );

  modport slave (
    input rx_active, rx_pkt_start, rx_bit_valid, rx_bit, rx_pkt_end, rx_err, dbg_state
  );

endinterface

// File: rtl/usb_rx_dpll.sv
// Pad synchroniser, line-state decode and 4x bit-clock recovery.
// Optional glitch filter enabled by defining USB_RX_GLITCH_FILTER_EN.
module usb_rx_dpll
  import usb_fs_rx_pkg::*;
(
  input  logic        clk_usb,
  input  logic        reset_n,
  input  logic        i_p,
  input  logic        i_n,
  output line_state_t o_line_state,
  output logic        o_sample_strobe
);

  logic        r_p_meta, r_p_sync, r_n_meta, r_n_sync;
  line_state_t w_raw, w_line, r_line_prev;
  logic [1:0]  r_phase, w_phase;
  logic        w_change;

  // Synchronisers reset to J so the bus looks idle straight out of reset.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      r_p_meta <= J_P;
      r_p_sync <= J_P;
      r_n_meta <= J_N;
      r_n_sync <= J_N;
    end else begin
      r_p_meta <= i_p;
      r_p_sync <= r_p_meta;
      r_n_meta <= i_n;
      r_n_sync <= r_n_meta;
    end
  end

  assign w_raw = decode_line(r_p_sync, r_n_sync);

`ifdef USB_RX_GLITCH_FILTER_EN
  line_state_t r_raw_d, r_line_f;

  // A new state passes once two consecutive samples agree; otherwise hold.
  assign w_line = (w_raw == r_raw_d) ? w_raw : r_line_f;

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      r_raw_d  <= J;
      r_line_f <= J;
    end else begin
      r_raw_d  <= w_raw;
      r_line_f <= w_line;
    end
  end
`else
  assign w_line = w_raw;
`endif

  // A transition realigns the phase in the same cycle, so a transition
  // landing on phase 2 suppresses that sample.
  assign w_change = (w_line != r_line_prev);
  assign w_phase  = w_change ? 2'd0 : r_phase;

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      r_line_prev <= J;
      r_phase     <= 2'd0;
    end else begin
      r_line_prev <= w_line;
      r_phase     <= w_phase + 2'd1;
    end
  end

  assign o_line_state    = w_line;
  assign o_sample_strobe = (w_phase == 2'd2);

endmodule

// File: rtl/usb_fs_rx_frontend.sv
// Full-speed USB receive front end: NRZI decode, SYNC detect, bit unstuffing
// and EOP framing on top of usb_rx_dpll (see USB_RX_GLITCH_FILTER_EN there).
module usb_fs_rx_frontend
  import usb_fs_rx_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = 5,
  parameter int EOP_MAX_SE0    = 3
) (
  input  logic                 clk_usb,
  input  logic                 reset_n,
  input  logic                 usb_p_rx,
  input  logic                 usb_n_rx,
  usb_fs_rx_frontend_if.master rx
);

  line_state_t w_ls, r_prev_jk;
  logic        w_strobe, w_jk, w_dec;
  rx_state_t   r_state, w_state_nxt;
  logic [2:0]  r_zeros, w_zeros_nxt, r_ones, w_ones_nxt, r_se0, w_se0_nxt;
  logic        r_seen_se0, w_seen_nxt;
  logic        w_valid, w_bit, w_start_nxt, w_end_nxt, w_err_nxt;
  logic        r_start, r_end, r_err, r_active;

  usb_rx_dpll u_dpll (
    .clk_usb         (clk_usb),
    .reset_n         (reset_n),
    .i_p             (usb_p_rx),
    .i_n             (usb_n_rx),
    .o_line_state    (w_ls),
    .o_sample_strobe (w_strobe)
  );

  assign w_jk  = (w_ls == J) || (w_ls == K);
  assign w_dec = (w_ls == r_prev_jk);

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_zeros_nxt = r_zeros;
    w_ones_nxt  = r_ones;
    w_se0_nxt   = r_se0;
    w_seen_nxt  = r_seen_se0;
    if (w_strobe) begin
      case (r_state)
        IDLE: if (w_ls == K) begin
          w_state_nxt = SYNC;
          w_zeros_nxt = 3'd1;
        end
        SYNC: begin
          if (!w_jk) w_state_nxt = IDLE;
          else if (!w_dec) begin
            if (r_zeros != 3'd7) w_zeros_nxt = r_zeros + 3'd1;
          end else if (r_zeros >= 3'(SYNC_MIN_ZEROS)) begin
            w_state_nxt = DATA;
            w_ones_nxt  = 3'd0;
          end else w_state_nxt = IDLE;
        end
        DATA: begin
          if (w_ls == SE0) begin
            w_state_nxt = EOP;
            w_se0_nxt   = 3'd1;
          end else if (w_ls == SE1) begin
            w_state_nxt = ABORT;
            w_seen_nxt  = 1'b0;
          end else if (r_ones == 3'(STUFF_RUN)) begin
            if (w_dec) begin
              w_state_nxt = ABORT;
              w_seen_nxt  = 1'b0;
            end else w_ones_nxt = 3'd0;
          end else w_ones_nxt = w_dec ? r_ones + 3'd1 : 3'd0;
        end
        EOP: begin
          if (w_ls == SE0) begin
            if (r_se0 >= 3'(EOP_MAX_SE0)) begin
              w_state_nxt = ABORT;
              w_seen_nxt  = 1'b1;
            end else w_se0_nxt = r_se0 + 3'd1;
          end else if (w_ls == J) w_state_nxt = IDLE;
          else begin
            w_state_nxt = ABORT;
            w_seen_nxt  = 1'b1;
          end
        end
        ABORT: begin
          if (w_ls == SE0) w_seen_nxt = 1'b1;
          else if (w_ls == J && r_seen_se0) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Stuff bits (the bit after a full run of ones) never reach the consumer.
  always_comb begin
    w_valid     = w_strobe && (r_state == DATA) && w_jk && (r_ones != 3'(STUFF_RUN));
    w_bit       = w_valid && w_dec;
    w_start_nxt = w_strobe && (r_state == SYNC) && w_jk && w_dec &&
                  (r_zeros >= 3'(SYNC_MIN_ZEROS));
    w_err_nxt   = w_strobe && (r_state == ABORT) && (w_ls == J) && r_seen_se0;
    w_end_nxt   = w_err_nxt || (w_strobe && (r_state == EOP) && (w_ls == J));
  end

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_jk  <= J;
      r_zeros    <= 3'd0;
      r_ones     <= 3'd0;
      r_se0      <= 3'd0;
      r_seen_se0 <= 1'b0;
      r_start    <= 1'b0;
      r_end      <= 1'b0;
      r_err      <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_zeros    <= w_zeros_nxt;
      r_ones     <= w_ones_nxt;
      r_se0      <= w_se0_nxt;
      r_seen_se0 <= w_seen_nxt;
      r_start    <= w_start_nxt;
      r_end      <= w_end_nxt;
      r_err      <= w_err_nxt;
      if (w_end_nxt)             r_prev_jk <= J;
      else if (w_strobe && w_jk) r_prev_jk <= w_ls;
      if (w_start_nxt)           r_active  <= 1'b1;
      else if (r_end)            r_active  <= 1'b0;
    end
  end

  assign rx.rx_active    = r_active;
  assign rx.rx_pkt_start = r_start;
  assign rx.rx_bit_valid = w_valid;
  assign rx.rx_bit       = w_bit;
  assign rx.rx_pkt_end   = r_end;
  assign rx.rx_err       = r_err;
  assign rx.dbg_state    = r_state;

endmodule

// File: tb/tb_usb_fs_rx_frontend.sv
// Self-checking bench for usb_fs_rx_frontend: NRZI/stuffing encoder drives the pads,
// a scoreboard queue holds expected payload bits and end-of-packet error flags.
module tb_usb_fs_rx_frontend;
  import usb_fs_rx_pkg::*;

  logic clk_usb  = 1'b0;
  logic reset_n  = 1'b0;
  logic usb_p_rx = 1'b1;
  logic usb_n_rx = 1'b0;

  usb_fs_rx_frontend_if rx();

  usb_fs_rx_frontend dut (
    .clk_usb  (clk_usb),
    .reset_n  (reset_n),
    .usb_p_rx (usb_p_rx),
    .usb_n_rx (usb_n_rx),
    .rx       (rx)
  );

  // ---------------- clock / reset ----------------
  always #10 clk_usb = ~clk_usb;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  int          n_start  = 0;
  int          n_end    = 0;
  logic [0:0]  exp_q[$];
  logic [0:0]  exp_err_q[$];
  logic [0:0]  m_exp;
  logic        prev_end = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk_usb) begin
    if (reset_n) begin
      if (prev_end) chk("active_drop_after_end", int'(rx.rx_active), 0);
      prev_end = rx.rx_pkt_end;
      if (rx.rx_bit_valid) begin
        if (exp_q.size() == 0) chk("unexpected_bit_valid", 1, 0);
        else begin
          m_exp = exp_q.pop_front();
          chk("rx_bit", int'(rx.rx_bit), int'(m_exp));
          chk("active_during_bits", int'(rx.rx_active), 1);
        end
      end
      if (rx.rx_pkt_start) begin
        n_start++;
        chk("start_active", int'(rx.rx_active), 1);
        chk("start_not_with_valid", int'(rx.rx_bit_valid), 0);
      end
      if (rx.rx_pkt_end) begin
        n_end++;
        if (exp_err_q.size() == 0) chk("unexpected_pkt_end", 1, 0);
        else begin
          m_exp = exp_err_q.pop_front();
          chk("end_err", int'(rx.rx_err), int'(m_exp));
        end
      end else if (rx.rx_err) chk("err_without_end", 1, 0);
    end else prev_end = 1'b0;
  end

  // ---------------- drivers ----------------
  line_state_t cur_ls    = J;
  int          bit_idx   = 0;
  bit          jitter_on = 1'b0;

  task automatic drive_ls(input line_state_t ls, input int cycles);
    case (ls)
      J:       begin usb_p_rx = 1'b1; usb_n_rx = 1'b0; end
      K:       begin usb_p_rx = 1'b0; usb_n_rx = 1'b1; end
      SE0:     begin usb_p_rx = 1'b0; usb_n_rx = 1'b0; end
      default: begin usb_p_rx = 1'b1; usb_n_rx = 1'b1; end
    endcase
    repeat (cycles) @(posedge clk_usb);
    #1;
  endtask

  function automatic int bit_period();
    return jitter_on ? ((bit_idx % 2 == 1) ? 5 : 3) : 4;
  endfunction

  task automatic send_bit(input logic b);
    int per;
    per = bit_period();
    bit_idx++;
    if (!b) cur_ls = (cur_ls == J) ? K : J;
    drive_ls(cur_ls, per);
  endtask

  task automatic send_se0(input int nbits);
    int per;
    for (int i = 0; i < nbits; i++) begin
      per = bit_period();
      bit_idx++;
      drive_ls(SE0, per);
    end
    cur_ls = J;
  endtask

  task automatic send_sync(input int nz);
    for (int i = 0; i < nz; i++) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] data, input bit stuff);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(data[i]);
      send_bit(data[i]);
      ones = data[i] ? ones + 1 : 0;
      if (stuff && ones == STUFF_RUN) begin
        send_bit(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic idle_j(input int cycles);
    cur_ls = J;
    drive_ls(J, cycles);
  endtask

  task automatic check_done(input string tag, input int st0, input int en0,
                            input int d_start, input int d_end);
    chk({tag, "_bits_left"}, exp_q.size(), 0);
    chk({tag, "_ends_left"}, exp_err_q.size(), 0);
    chk({tag, "_starts"}, n_start - st0, d_start);
    chk({tag, "_ends"}, n_end - en0, d_end);
    chk({tag, "_active_idle"}, int'(rx.rx_active), 0);
    chk({tag, "_state_idle"}, int'(rx.dbg_state), int'(IDLE));
    exp_q.delete();
    exp_err_q.delete();
  endtask

  typedef struct {
    logic [7:0] data;
    int         nz;
    bit         jit;
  } vec_t;

  vec_t vecs[8];
  int   st0, en0;

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{8'hA5, 7, 1'b0};
    vecs[1] = '{8'hFF, 7, 1'b0};
    vecs[2] = '{8'h3C, 7, 1'b1};
    vecs[3] = '{8'h00, 7, 1'b0};
    vecs[4] = '{8'h7E, 5, 1'b0};
    for (int i = 5; i < 8; i++)
      vecs[i] = '{8'($urandom_range(0, 255)), int'($urandom_range(5, 7)), 1'($urandom_range(0, 1))};

    repeat (4) @(posedge clk_usb);
    #1;
    chk("rst_active", int'(rx.rx_active), 0);
    chk("rst_start", int'(rx.rx_pkt_start), 0);
    chk("rst_valid", int'(rx.rx_bit_valid), 0);
    chk("rst_end", int'(rx.rx_pkt_end), 0);
    chk("rst_err", int'(rx.rx_err), 0);
    chk("rst_state", int'(rx.dbg_state), int'(IDLE));
    reset_n = 1'b1;

    st0 = n_start; en0 = n_end;
    idle_j(100);
    check_done("idle", st0, en0, 0, 0);

    for (int v = 0; v < 8; v++) begin
      st0 = n_start; en0 = n_end;
      bit_idx = 0;
      jitter_on = vecs[v].jit;
      send_sync(vecs[v].nz);
      send_byte(vecs[v].data, 1'b1);
      exp_err_q.push_back(1'b0);
      send_se0(2);
      idle_j(40);
      check_done($sformatf("vec%0d", v), st0, en0, 1, 1);
    end
    jitter_on = 1'b0;

    // SYNC with too few zeros is dropped silently.
    st0 = n_start; en0 = n_end;
    send_sync(4);
    idle_j(40);
    check_done("short_sync", st0, en0, 0, 0);

    // Seventh consecutive 1 is a stuff error.
    st0 = n_start; en0 = n_end;
    send_sync(7);
    for (int i = 0; i < 7; i++) begin
      if (i < 6) exp_q.push_back(1'b1);
      send_bit(1'b1);
    end
    exp_err_q.push_back(1'b1);
    send_se0(2);
    idle_j(40);
    check_done("stuff_err", st0, en0, 1, 1);

    // SE0 longer than the EOP limit aborts the packet.
    st0 = n_start; en0 = n_end;
    send_sync(7);
    send_byte(8'h5A, 1'b1);
    exp_err_q.push_back(1'b1);
    send_se0(5);
    idle_j(40);
    check_done("long_se0", st0, en0, 1, 1);

    // Reset mid-packet: outputs clear at once and no end is reported.
    st0 = n_start; en0 = n_end;
    send_sync(7);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(1'(8'h0D >> i));
      send_bit(1'(8'h0D >> i));
    end
    cur_ls = K;
    drive_ls(cur_ls, 2);
    chk("pre_rst_active", int'(rx.rx_active), 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_active", int'(rx.rx_active), 0);
    chk("midrst_valid", int'(rx.rx_bit_valid), 0);
    chk("midrst_end", int'(rx.rx_pkt_end), 0);
    chk("midrst_err", int'(rx.rx_err), 0);
    drive_ls(cur_ls, 2);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    send_se0(2);
    idle_j(20);
    reset_n = 1'b1;
    idle_j(40);
    check_done("mid_reset", st0, en0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_fs_rx_frontend.md
# usb_fs_rx_frontend

Full-speed USB receive front end between the pad input buffers (usb_p_rx / usb_n_rx, forced to J by the board wrapper while transmitting) and the bootloader's packet decoder. It synchronises the raw differential pair into clk_usb and recovers the 12 Mbit/s bit clock from 4x oversampling with a phase counter. It then NRZI-decodes, detects SYNC, removes stuffed bits and detects EOP, and presents a framed serial bit stream with start, end and error flags.

## Interface
- SYNC_MIN_ZEROS, 5: minimum decoded 0 bits before the terminating 1 that completes SYNC.
- EOP_MAX_SE0, 3: maximum SE0 bit-times accepted inside a valid EOP.
- clk_usb  in  1  48 MHz clock; the block's only clock.
- reset_n  in  1  asynchronous assert, active-low reset.
- usb_p_rx  in  1  raw D+ from pad, asynchronous to clk_usb.
- usb_n_rx  in  1  raw D- from pad, asynchronous to clk_usb.
- rx_active  out  1  high from pkt_start until the cycle after pkt_end.
- rx_pkt_start  out  1  one-cycle pulse when SYNC completes.
- rx_bit_valid  out  1  one-cycle strobe; rx_bit holds a de-stuffed payload bit.
- rx_bit  out  1  decoded payload bit, sent LSB-first as on the wire.
- rx_pkt_end  out  1  one-cycle pulse ending every packet, whether good or aborted.
- rx_err  out  1  qualifies rx_pkt_end: 1 means stuff error, SE1, or malformed EOP.

## Operation
- Synchroniser: two flops per line. Line state is decoded from the synchronised pair: J = p1/n0, K = p0/n1, SE0 = 00, SE1 = 11.
- DPLL: 2-bit phase counter that increments every cycle.
  - A change of synchronised line state forces phase to 0.
  - The bit sample is taken at phase 2, which is mid-bit. Exactly one sample is taken per 4 cycles when there are no transitions.
- NRZI: at each sample, decoded bit = 1 if the line state equals the previous sampled J/K state, and 0 if it differs. The previous state resets to J.
- FSM states: IDLE, SYNC, DATA, EOP, ABORT.
- IDLE -> SYNC on the first sampled K. The zero counter starts at 1.
- SYNC:
  - Each decoded 0 increments the zero counter, saturating at 7.
  - A decoded 1 with count >= SYNC_MIN_ZEROS goes to DATA and pulses rx_pkt_start.
  - A decoded 1 with count < SYNC_MIN_ZEROS returns to IDLE with no outputs.
  - SE0 or SE1 returns to IDLE silently.
- DATA:
  - Ones counter: incremented on a decoded 1, cleared on a decoded 0.
  - The bit following six consecutive 1s is a stuff bit.
    - If it is 0, it is dropped: no rx_bit_valid and the counter clears.
    - If it is 1, go to ABORT.
  - Every other bit produces rx_bit_valid/rx_bit.
  - A sampled SE0 goes to EOP with the SE0 count = 1. A sampled SE1 goes to ABORT.
- EOP:
  - Further SE0 samples increment the SE0 count.
  - A J sample with count in 1..EOP_MAX_SE0 pulses rx_pkt_end with rx_err=0, then goes to IDLE.
  - A K sample, SE1, or count > EOP_MAX_SE0 goes to ABORT.
- ABORT: wait for a J sample that follows at least one SE0 sample. Then pulse rx_pkt_end with rx_err=1 and go to IDLE.
  - Bus reset (long SE0) is handled the same way: the packet ends with an error once J returns.
- Bits already emitted before an error are not retracted. Consumers discard the packet when rx_err=1.
- SE0/SE1 samples never update the NRZI previous state. After an EOP, the previous state reloads to J.

## Timing
- All outputs reset to 0; the FSM resets to IDLE; all counters reset to 0; the phase resets to 0.
- Pad-to-line-state latency: 2 cycles, or 3 with the filter compiled in.
- rx_bit_valid fires in the same cycle as the phase-2 sample. rx_pkt_start and rx_pkt_end are registered in the sample cycle and appear the following cycle.
- rx_pkt_start never coincides with rx_bit_valid. The first payload bit follows at least 4 cycles later.
- rx_pkt_end is asserted at most once per rx_pkt_start.
- rx_active drops in the cycle after rx_pkt_end.
- A transition landing on phase 2 takes priority: the phase resets and no sample is taken that cycle.
- When reset_n is asserted mid-packet, all outputs clear immediately and no rx_pkt_end is produced.
- No backpressure: the consumer must accept a bit every strobe.

## Configuration
- USB_RX_GLITCH_FILTER_EN defined:
  - A new line state is accepted only after 2 consecutive identical synchronised samples.
  - This adds 1 cycle of latency and suppresses single-cycle glitches, including transient SE0/SE1 at differential crossings.
- USB_RX_GLITCH_FILTER_EN undefined: the line state follows the synchroniser output directly.

## Structure
- Shared package usb_fs_rx_pkg holds:
  - line_state_t enum {J, K, SE0, SE1};
  - rx_state_t enum {IDLE, SYNC, DATA, EOP, ABORT};
  - constant STUFF_RUN = 6;
  - the J encoding constants.
- Sub-module usb_rx_dpll contains the synchroniser, the optional filter, the line-state decode, and the phase counter.
  - Outputs: line_state and sample_strobe.
  - The top level holds the NRZI, SYNC, unstuff, and EOP FSM.

## Test plan
- Idle J for 100 cycles -> no strobes, no pulses, rx_active=0.
- SYNC KJKJKJKK, then byte 0xA5, then SE0 for 2 bits, then J. All bit-times are 4 cycles.
  - Expected: one rx_pkt_start, then 8 rx_bit_valid carrying 1,0,1,0,0,1,0,1.
  - Then rx_pkt_end with rx_err=0.
- Payload 0xFF (eight 1s), correctly stuffed -> 8 valid bits, all 1. The stuff bit after the sixth 1 produces no strobe.
- Seven 1s without a stuff bit -> no further rx_bit_valid after the sixth 1. After the SE0 then J, rx_pkt_end with rx_err=1.
- Bit-time jitter: alternate 3- and 5-cycle bit periods across a 0x3C payload -> all bits decoded correctly via phase resync.
- SE0 for 5 bit-times mid-DATA (EOP_MAX_SE0 = 3), then J -> rx_pkt_end with rx_err=1. Separately, reset_n pulsed mid-packet -> outputs 0 and no rx_pkt_end.
